prog_clk_div: RTL and testbench

Runtime-programmable clock divider producing a 50%-duty output for any integer divisor, odd or even, from a single input clock. It generalises the fixed odd-divide block: parametrised divisor width, divisor reloadable on the fly with glitch-free switching at period boundaries, and clean enable/disable. It sits between the board oscillator (100 MHz) and slow peripheral logic, and also provides a one-cycle `tick` strobe for logic that stays on `clk_in`.

---
 rtl/clk_div_pkg.sv | 20 ++
 rtl/prog_clk_div_if.sv | 26 ++
 rtl/half_cycle_shift.sv | 13 +
 rtl/prog_clk_div.sv | 102 ++++++++++
 tb/tb_prog_clk_div.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds the FSM encoding, the minimum legal divisor and the duty helper.
package clk_div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } st_e;

  localparam int MIN_DIV = 2;

  // High-phase length of pos: D/2 for even D, (D+1)/2 for odd D
  function automatic logic [31:0] half_of(
    input logic [31:0] d,
    input logic        odd
  );
    return odd ? ((d + 32'd1) >> 1) : (d >> 1);
  endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Control/status bundle of the programmable clock divider.
// master drives requests, slave is the divider itself.
interface prog_clk_div_if #(
  parameter int W = 8
);
  logic         en;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_ack;
  logic         div_err;
  logic [W-1:0] cur_div;
  logic         clk_out;
  logic         tick;

  modport master (
    output en, div_in, div_load,
    input  div_ack, div_err, cur_div,
    input  clk_out, tick
  );

  modport slave (
    input  en, div_in, div_load,
    output div_ack, div_err, cur_div,
    output clk_out, tick
  );
endinterface

// File: rtl/half_cycle_shift.sv
// Negedge re-registration of a posedge signal, async active-low clear.
// Delays its input by half an input clock period.
module half_cycle_shift (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end
endmodule

// File: rtl/prog_clk_div.sv
// Runtime-programmable 50%-duty clock divider with tick strobe.
// Odd divisors AND pos with its half-cycle-delayed copy.
module prog_clk_div #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 3
) (
  input logic           clk_in,
  input logic           rst_n,
  prog_clk_div_if.slave bus
);
  import clk_div_pkg::*;

  localparam logic [W-1:0] DEF = W'(DEFAULT_DIV);

  st_e          state;
  st_e          st_nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] cur_div;
  logic [W-1:0] d_nxt;
  logic [W-1:0] pend;
  logic         pend_v;
  logic         pos;
  logic         pos_nxt;
  logic         neg;
  logic         tick;
  logic         ack;
  logic         err;
  logic         bnd;
  logic         load_ok;
  logic         apply;

  always_comb begin
    bnd     = (state == ST_RUN)
            && (cnt == cur_div - W'(1));
    load_ok = bus.div_load
            && (bus.div_in >= W'(MIN_DIV));
    apply   = pend_v
            && ((state == ST_IDLE) || bnd);
    d_nxt   = apply ? pend : cur_div;
    st_nxt  = state;
    cnt_nxt = '0;
    unique case (state)
      ST_IDLE: begin
        if (bus.en) st_nxt = ST_RUN;
      end
      ST_RUN: begin
        // en only matters at a boundary
        if (!bnd)         cnt_nxt = cnt + W'(1);
        else if (!bus.en) st_nxt  = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
    pos_nxt = (st_nxt == ST_RUN)
            && (32'(cnt_nxt)
                < half_of(32'(d_nxt), d_nxt[0]));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cur_div <= DEF;
      pend    <= '0;
      pend_v  <= 1'b0;
      pos     <= 1'b0;
      tick    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= st_nxt;
      cnt     <= cnt_nxt;
      cur_div <= d_nxt;
      pos     <= pos_nxt;
      tick    <= (st_nxt == ST_RUN)
              && (cnt_nxt == '0);
      ack     <= apply;
      err     <= bus.div_load && !load_ok;
      // a fresh load wins over clearing the applied one
      if (load_ok) begin
        pend   <= bus.div_in;
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

  half_cycle_shift u_shift (
    .clk   (clk_in),
    .rst_n (rst_n),
    .d     (pos),
    .q     (neg)
  );

  assign bus.clk_out = cur_div[0] ? (pos & neg) : pos;
  assign bus.tick    = tick;
  assign bus.div_ack = ack;
  assign bus.div_err = err;
  assign bus.cur_div = cur_div;

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: edge timing, tick, load/ack/err, stop, reset.
// Divisors applied are checked against a queue filled at load time.
module tb_prog_clk_div;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int checks   = 0;
  int errors   = 0;
  int rise_cnt = 0;
  int tick_cnt = 0;
  int ack_cnt  = 0;
  int err_cnt  = 0;

  longint last_rise = -1;
  longint period    = 0;
  longint high_w    = 0;
  longint min_high  = 0;

  logic [W-1:0] sb[$];

  prog_clk_div_if #(.W(W)) bus ();

  prog_clk_div #(
    .W           (W),
    .DEFAULT_DIV (3)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string  tag,
    input longint obs,
    input longint exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  always @(posedge bus.clk_out) begin
    rise_cnt++;
    if (last_rise >= 0)
      period = longint'($time) - last_rise;
    last_rise = longint'($time);
  end

  always @(negedge bus.clk_out) begin
    high_w = longint'($time) - last_rise;
    if (high_w < min_high) min_high = high_w;
  end

  always @(negedge clk) begin
    if (bus.tick)    tick_cnt++;
    if (bus.div_err) err_cnt++;
    if (bus.div_ack) begin
      ack_cnt++;
      check("sb_nonempty",
            longint'(sb.size() != 0), 1);
      if (sb.size() != 0)
        check("ack_div",
              longint'(bus.cur_div),
              longint'(sb.pop_front()));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rises(input int n);
    int tgt;
    int c;
    tgt = rise_cnt + n;
    c   = 0;
    while (rise_cnt < tgt && c < n * 20) begin
      step();
      c++;
    end
    check("rise_timeout",
          longint'(rise_cnt >= tgt), 1);
  endtask

  task automatic sync_tick();
    int c;
    c = 0;
    step();
    while (!bus.tick && c < 40) begin
      step();
      c++;
    end
    check("tick_timeout", longint'(bus.tick), 1);
  endtask

  task automatic load(input logic [W-1:0] d);
    bus.div_in   = d;
    bus.div_load = 1'b1;
  endtask

  initial begin
    int r;
    int c;
    bus.en       = 1'b0;
    bus.div_in   = '0;
    bus.div_load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_clk_out", longint'(bus.clk_out), 0);
    check("rst_cur_div", longint'(bus.cur_div), 3);
    check("rst_tick",    longint'(bus.tick), 0);
    check("rst_ack",     longint'(bus.div_ack), 0);
    check("rst_err",     longint'(bus.div_err), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_clk_out", longint'(bus.clk_out), 0);

    // D=3 free run
    bus.en = 1'b1;
    wait_rises(3);
    check("d3_period", period, 30);
    check("d3_high",   high_w, 15);
    check("d3_cur",    longint'(bus.cur_div), 3);
    tick_cnt = 0;
    repeat (9) step();
    check("d3_ticks", longint'(tick_cnt), 3);

    // D=4 loaded mid-period
    sync_tick();
    ack_cnt  = 0;
    min_high = 1000;
    load(8'd4);
    sb.push_back(8'd4);
    step();
    bus.div_load = 1'b0;
    check("d4_no_early_ack", longint'(ack_cnt), 0);
    check("d4_old_cur", longint'(bus.cur_div), 3);
    wait_rises(4);
    check("d4_period", period, 40);
    check("d4_high",   high_w, 20);
    check("d4_acks",   longint'(ack_cnt), 1);
    check("d4_cur",    longint'(bus.cur_div), 4);
    check("d4_no_runt", longint'(min_high >= 15), 1);

    // 5 then 7 in one period: only 7 lands
    sync_tick();
    ack_cnt = 0;
    load(8'd5);
    step();
    load(8'd7);
    sb.push_back(8'd7);
    step();
    bus.div_load = 1'b0;
    wait_rises(4);
    check("d7_period", period, 70);
    check("d7_high",   high_w, 35);
    check("d7_acks",   longint'(ack_cnt), 1);
    check("d7_cur",    longint'(bus.cur_div), 7);

    // illegal divisors
    err_cnt = 0;
    ack_cnt = 0;
    load(8'd1);
    step();
    check("err1_pulse", longint'(bus.div_err), 1);
    load(8'd0);
    step();
    check("err0_pulse", longint'(bus.div_err), 1);
    bus.div_load = 1'b0;
    step();
    check("err_clear", longint'(bus.div_err), 0);
    check("err_cnt",   longint'(err_cnt), 2);
    wait_rises(2);
    check("err_cur",    longint'(bus.cur_div), 7);
    check("err_period", period, 70);
    check("err_acks",   longint'(ack_cnt), 0);

    // D=6, then stop mid-period
    load(8'd6);
    sb.push_back(8'd6);
    step();
    bus.div_load = 1'b0;
    wait_rises(4);
    check("d6_period", period, 60);
    check("d6_high",   high_w, 30);
    sync_tick();
    step();
    bus.en = 1'b0;
    step();
    check("stop_still_hi", longint'(bus.clk_out), 1);
    repeat (8) step();
    check("stop_high", high_w, 30);
    check("stop_low",  longint'(bus.clk_out), 0);
    tick_cnt = 0;
    r = rise_cnt;
    repeat (20) step();
    check("stop_ticks", longint'(tick_cnt), 0);
    check("stop_rises", longint'(rise_cnt - r), 0);
    check("stop_clk",   longint'(bus.clk_out), 0);
    bus.en = 1'b1;
    step();
    check("restart_clk",  longint'(bus.clk_out), 1);
    check("restart_tick", longint'(bus.tick), 1);
    check("restart_edge",
          longint'($time) - last_rise, 6);

    // reset while high with D=5 and a pending load
    load(8'd5);
    sb.push_back(8'd5);
    step();
    bus.div_load = 1'b0;
    wait_rises(3);
    c = 0;
    while (!bus.clk_out && c < 20) begin
      step();
      c++;
    end
    check("d5_high_seen", longint'(bus.clk_out), 1);
    load(8'd9);
    step();
    bus.div_load = 1'b0;
    check("pre_rst_high", longint'(bus.clk_out), 1);
    ack_cnt = 0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_drop", longint'(bus.clk_out), 0);
    check("rst_cur",  longint'(bus.cur_div), 3);
    bus.en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_cur",  longint'(bus.cur_div), 3);
    check("post_rst_acks", longint'(ack_cnt), 0);
    bus.en = 1'b1;
    step();
    check("e0_tick", longint'(bus.tick), 1);
    check("e0_clk",  longint'(bus.clk_out), 1);
    wait_rises(3);
    check("post_rst_period", period, 30);
    check("sb_drained", longint'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
